// File: rtl/tlu_fifo_write_arbiter.sv
// Arbitrates the shared SRAM-FIFO write port between buffered TLU trigger words and FE data words.
// Triggers take priority, but bursts are bounded so a waiting FE word is granted periodically.
module tlu_fifo_write_arbiter #(
  parameter int TRIG_DEPTH_LOG2 = 2,
  parameter int MAX_TRIG_BURST  = 4
) (
  input  logic        BUS_CLK,
  input  logic        BUS_RST,
  input  logic        ENABLE,
  input  logic        CLEAR_LOST,
  input  logic [30:0] TLU_DATA,
  input  logic        TLU_DATA_SAVE_FLAG,
  output logic        TLU_DATA_SAVED_FLAG,
  input  logic [30:0] FE_DATA,
  input  logic        FE_VALID,
  output logic        FE_READY,
  output logic [31:0] FIFO_DATA,
  output logic        FIFO_WRITE,
  input  logic        FIFO_FULL,
  input  logic        FIFO_NEAR_FULL,
  output logic        TRIGGER_PENDING,
  output logic [7:0]  TRIGGER_LOST_CNT
);

  localparam int DEPTH = 1 << TRIG_DEPTH_LOG2;
  localparam logic [3:0] MAX_BURST = 4'(MAX_TRIG_BURST);
  localparam logic [TRIG_DEPTH_LOG2:0]   CNT_ONE = 1;
  localparam logic [TRIG_DEPTH_LOG2-1:0] PTR_ONE = 1;

  logic [30:0]                trig_mem [DEPTH];
  logic [TRIG_DEPTH_LOG2-1:0] wr_ptr;
  logic [TRIG_DEPTH_LOG2-1:0] rd_ptr;
  logic [TRIG_DEPTH_LOG2:0]   trig_cnt;
  logic [TRIG_DEPTH_LOG2:0]   trig_cnt_nxt;
  logic [3:0]                 burst_cnt;

  logic pending;
  logic buf_full;
  logic can_write;
  logic burst_done;
  logic grant_trig;
  logic grant_fe;
  logic push;
  logic drop;
  logic push_ok;

  // The count carries one extra bit, so its MSB alone marks a completely full buffer.
  assign pending    = (trig_cnt != '0);
  assign buf_full   = trig_cnt[TRIG_DEPTH_LOG2];
  assign can_write  = ENABLE && !FIFO_FULL;
  assign burst_done = (burst_cnt >= MAX_BURST);
  assign grant_trig = can_write && pending && (!burst_done || !FE_VALID || FIFO_NEAR_FULL);
  assign grant_fe   = can_write && !grant_trig && FE_VALID && !FIFO_NEAR_FULL;
  assign push       = TLU_DATA_SAVE_FLAG && ENABLE;
  assign drop       = push && buf_full && !grant_trig;
  assign push_ok    = push && !drop;
  assign FE_READY   = grant_fe;

  always_comb begin
    trig_cnt_nxt = trig_cnt;
    if (!ENABLE) begin
      trig_cnt_nxt = '0;
    end else if (push_ok && !grant_trig) begin
      trig_cnt_nxt = trig_cnt + CNT_ONE;
    end else if (!push_ok && grant_trig) begin
      trig_cnt_nxt = trig_cnt - CNT_ONE;
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (push_ok) begin
      trig_mem[wr_ptr] <= TLU_DATA;
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      trig_cnt            <= '0;
      burst_cnt           <= '0;
      FIFO_WRITE          <= 1'b0;
      FIFO_DATA           <= '0;
      TLU_DATA_SAVED_FLAG <= 1'b0;
      TRIGGER_PENDING     <= 1'b0;
      TRIGGER_LOST_CNT    <= '0;
    end else begin
      // Disabling flushes the buffer without counting the flushed words as lost.
      if (!ENABLE) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (grant_trig) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
      end
      trig_cnt        <= trig_cnt_nxt;
      TRIGGER_PENDING <= (trig_cnt_nxt != '0);

      FIFO_WRITE          <= grant_trig || grant_fe;
      TLU_DATA_SAVED_FLAG <= grant_trig;
      if (grant_trig) begin
        FIFO_DATA <= {1'b1, trig_mem[rd_ptr]};
      end else if (grant_fe) begin
        FIFO_DATA <= {1'b0, FE_DATA};
      end

      if (can_write) begin
        if (grant_trig) begin
          if (!burst_done) begin
            burst_cnt <= burst_cnt + 4'd1;
          end
        end else begin
          burst_cnt <= '0;
        end
      end

      // A clear wins over the old count but not over a drop in the same cycle.
      if (CLEAR_LOST) begin
        TRIGGER_LOST_CNT <= drop ? 8'd1 : 8'd0;
      end else if (drop && (TRIGGER_LOST_CNT != 8'hFF)) begin
        TRIGGER_LOST_CNT <= TRIGGER_LOST_CNT + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_tlu_fifo_write_arbiter.sv
// Bench for tlu_fifo_write_arbiter: directed vector table, hand-written corner sequences and
// randomized traffic, all checked against a queue-based reference model.
module tb_tlu_fifo_write_arbiter;

  localparam int DEPTH = 4;
  localparam int MAX   = 4;

  logic        clk = 1'b0;
  logic        bus_rst, enable, clear_lost, save_flag, saved_flag;
  logic [30:0] tlu_data, fe_data;
  logic        fe_valid, fe_ready, fifo_write, fifo_full, near_full, trig_pending;
  logic [31:0] fifo_data;
  logic [7:0]  lost_cnt;

  always #5 clk = ~clk;

  tlu_fifo_write_arbiter #(.TRIG_DEPTH_LOG2(2), .MAX_TRIG_BURST(MAX)) dut (
    .BUS_CLK(clk), .BUS_RST(bus_rst), .ENABLE(enable), .CLEAR_LOST(clear_lost),
    .TLU_DATA(tlu_data), .TLU_DATA_SAVE_FLAG(save_flag), .TLU_DATA_SAVED_FLAG(saved_flag),
    .FE_DATA(fe_data), .FE_VALID(fe_valid), .FE_READY(fe_ready),
    .FIFO_DATA(fifo_data), .FIFO_WRITE(fifo_write), .FIFO_FULL(fifo_full),
    .FIFO_NEAR_FULL(near_full), .TRIGGER_PENDING(trig_pending), .TRIGGER_LOST_CNT(lost_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: pending triggers in arrival order plus expected registered outputs.
  logic [30:0] mq[$];
  int          m_burst = 0;
  int          m_lost  = 0;
  logic        e_write = 0, e_saved = 0;
  logic [31:0] e_data  = 0;

  typedef struct {
    logic        en, save;
    logic [30:0] tlu;
    logic        fev;
    logic [30:0] fe;
    logic        near;
    logic        x_ready, x_write, x_saved;
    logic [31:0] x_data;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic addv(input logic save, input logic [30:0] tlu, input logic fev, input logic near,
                      input logic x_ready, input logic x_write, input logic x_saved,
                      input logic [31:0] x_data);
    vec_t v;
    v.en = 1'b1; v.save = save; v.tlu = tlu; v.fev = fev; v.fe = 31'h0AA; v.near = near;
    v.x_ready = x_ready; v.x_write = x_write; v.x_saved = x_saved; v.x_data = x_data;
    vecs.push_back(v);
  endtask

  // One clock cycle: inputs applied now (just after an edge), FE_READY checked at the falling
  // edge, registered outputs checked just after the next rising edge.
  task automatic drive_cycle(input logic rst, input logic en, input logic save,
                             input logic [30:0] tlu, input logic fev, input logic [30:0] fe,
                             input logic full, input logic near, input logic clr,
                             output logic ready_seen);
    logic m_trig, m_fe, en_ok, drop;
    bus_rst = rst; enable = en; save_flag = save; tlu_data = tlu; fe_valid = fev;
    fe_data = fe; fifo_full = full; near_full = near; clear_lost = clr;
    @(negedge clk);
    m_trig = 1'b0; m_fe = 1'b0;
    en_ok  = en && !full;
    ready_seen = 1'b0;
    if (!rst) begin
      m_trig = en_ok && (mq.size() > 0) && ((m_burst < MAX) || !fev || near);
      m_fe   = en_ok && !m_trig && fev && !near;
      chk("fe_ready", {31'b0, fe_ready}, {31'b0, m_fe});
      ready_seen = fe_ready;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
      m_burst = 0; m_lost = 0;
      e_write = 0; e_saved = 0; e_data = 0;
    end else begin
      if (en_ok) begin
        if (m_trig) m_burst = (m_burst < MAX) ? m_burst + 1 : MAX;
        else        m_burst = 0;
      end
      e_write = m_trig || m_fe;
      e_saved = m_trig;
      if (m_trig)    e_data = {1'b1, mq.pop_front()};
      else if (m_fe) e_data = {1'b0, fe};
      drop = 1'b0;
      if (!en) mq.delete();
      else if (save) begin
        if (mq.size() < DEPTH) mq.push_back(tlu);
        else drop = 1'b1;
      end
      if (clr)       m_lost = drop ? 1 : 0;
      else if (drop) m_lost = (m_lost < 255) ? m_lost + 1 : 255;
    end
    chk("fifo_write", {31'b0, fifo_write}, {31'b0, e_write});
    chk("saved_flag", {31'b0, saved_flag}, {31'b0, e_saved});
    chk("trig_pending", {31'b0, trig_pending}, {31'b0, (mq.size() != 0)});
    chk("lost_cnt", {24'b0, lost_cnt}, 32'(m_lost));
    if (e_write || rst) chk("fifo_data", fifo_data, e_data);
  endtask

  task automatic idle(input int n, input logic full);
    logic r;
    for (int i = 0; i < n; i++) drive_cycle(0, 1, 0, 0, 0, 0, full, 0, 0, r);
  endtask

  initial begin
    logic        r;
    logic [31:0] got[$];
    logic        fv;
    logic [30:0] fd;

    bus_rst = 1; enable = 0; clear_lost = 0; save_flag = 0; tlu_data = 0;
    fe_valid = 0; fe_data = 0; fifo_full = 0; near_full = 0;
    @(posedge clk); #1;
    drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, r);
    drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, r);
    chk("reset_write", {31'b0, fifo_write}, 32'd0);
    chk("reset_data", fifo_data, 32'd0);
    idle(2, 0);

    // Single trigger, then T,T,T,T,FE,T,T,FE under a held FE_VALID, then near-full triggers.
    addv(1, 31'h1234, 0, 0, 0, 0, 0, 0);
    addv(0, 0,        0, 0, 0, 1, 1, 32'h8000_1234);
    addv(0, 0,        0, 0, 0, 0, 0, 0);
    addv(1, 31'h100,  0, 0, 0, 0, 0, 0);
    addv(1, 31'h101,  1, 0, 0, 1, 1, 32'h8000_0100);
    addv(1, 31'h102,  1, 0, 0, 1, 1, 32'h8000_0101);
    addv(1, 31'h103,  1, 0, 0, 1, 1, 32'h8000_0102);
    addv(1, 31'h104,  1, 0, 0, 1, 1, 32'h8000_0103);
    addv(1, 31'h105,  1, 0, 1, 1, 0, 32'h0000_00AA);
    addv(0, 0,        1, 0, 0, 1, 1, 32'h8000_0104);
    addv(0, 0,        1, 0, 0, 1, 1, 32'h8000_0105);
    addv(0, 0,        1, 0, 1, 1, 0, 32'h0000_00AA);
    addv(0, 0,        0, 0, 0, 0, 0, 0);
    addv(1, 31'h200,  1, 1, 0, 0, 0, 0);
    addv(1, 31'h201,  1, 1, 0, 1, 1, 32'h8000_0200);
    addv(0, 0,        1, 1, 0, 1, 1, 32'h8000_0201);
    addv(0, 0,        1, 1, 0, 0, 0, 0);
    addv(0, 0,        0, 0, 0, 0, 0, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      drive_cycle(0, vecs[i].en, vecs[i].save, vecs[i].tlu, vecs[i].fev, vecs[i].fe,
                  0, vecs[i].near, 0, r);
      chk($sformatf("vec%0d_ready", i), {31'b0, r}, {31'b0, vecs[i].x_ready});
      chk($sformatf("vec%0d_write", i), {31'b0, fifo_write}, {31'b0, vecs[i].x_write});
      chk($sformatf("vec%0d_saved", i), {31'b0, saved_flag}, {31'b0, vecs[i].x_saved});
      if (vecs[i].x_write) chk($sformatf("vec%0d_data", i), fifo_data, vecs[i].x_data);
    end

    // FIFO full while six triggers arrive: two dropped, four written in order afterwards.
    for (int i = 0; i < 6; i++) drive_cycle(0, 1, 1, 31'(32'h300 + i), 0, 0, 1, 0, 0, r);
    chk("full_lost", {24'b0, lost_cnt}, 32'd2);
    chk("full_pending", {31'b0, trig_pending}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      drive_cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, r);
      if (fifo_write) got.push_back(fifo_data);
    end
    chk("drain_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < got.size() && i < 4; i++)
      chk($sformatf("drain%0d", i), got[i], 32'h8000_0300 + 32'(i));

    // Full buffer with pop and push together, saturation, and clear interactions.
    drive_cycle(0, 1, 0, 0, 0, 0, 0, 0, 1, r);
    chk("clear_lost", {24'b0, lost_cnt}, 32'd0);
    for (int i = 0; i < 4; i++) drive_cycle(0, 1, 1, 31'(32'h400 + i), 0, 0, 1, 0, 0, r);
    drive_cycle(0, 1, 1, 31'h404, 0, 0, 0, 0, 0, r);
    chk("pop_push_nodrop", {24'b0, lost_cnt}, 32'd0);
    chk("pop_push_write", fifo_data, 32'h8000_0400);
    for (int i = 0; i < 300; i++) drive_cycle(0, 1, 1, 31'(i), 0, 0, 1, 0, 0, r);
    chk("lost_sat", {24'b0, lost_cnt}, 32'd255);
    drive_cycle(0, 1, 0, 0, 0, 0, 1, 0, 1, r);
    chk("clear_after_sat", {24'b0, lost_cnt}, 32'd0);
    drive_cycle(0, 1, 1, 31'h7, 0, 0, 1, 0, 1, r);
    chk("clear_with_drop", {24'b0, lost_cnt}, 32'd1);
    drive_cycle(0, 0, 0, 0, 0, 0, 1, 0, 0, r);
    chk("flush_pending", {31'b0, trig_pending}, 32'd0);
    chk("flush_lost", {24'b0, lost_cnt}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, r);
      chk("flush_nowrite", {31'b0, fifo_write}, 32'd0);
    end

    // Reset in the middle of a burst with three words still buffered.
    for (int i = 0; i < 4; i++) drive_cycle(0, 1, 1, 31'(32'h500 + i), 0, 0, 1, 0, 0, r);
    drive_cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, r);
    chk("pre_rst_write", {31'b0, fifo_write}, 32'd1);
    drive_cycle(1, 1, 0, 0, 0, 0, 0, 0, 0, r);
    chk("rst_write", {31'b0, fifo_write}, 32'd0);
    chk("rst_data", fifo_data, 32'd0);
    chk("rst_pending", {31'b0, trig_pending}, 32'd0);
    chk("rst_lost", {24'b0, lost_cnt}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      drive_cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, r);
      chk("post_rst_nowrite", {31'b0, fifo_write}, 32'd0);
    end

    // Randomized traffic; the FE source holds its word until it is accepted.
    fv = 0; fd = 0;
    for (int i = 0; i < 3000; i++) begin
      logic rs, en, sv, fl, nf, cl;
      rs = ($urandom_range(0, 199) == 0);
      en = ($urandom_range(0, 19) != 0);
      sv = ($urandom_range(0, 9) < 3);
      fl = ($urandom_range(0, 19) < 3);
      nf = ($urandom_range(0, 9) < 2);
      cl = ($urandom_range(0, 49) == 0);
      if (!fv) begin
        fv = ($urandom_range(0, 1) == 1);
        fd = 31'($urandom());
      end
      drive_cycle(rs, en, sv, 31'($urandom()), fv, fd, fl, nf, cl, r);
      if (fv && r) fv = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
